// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding, the Booth recoding op-codes and the counter width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Recoding of the pair (Qx[0], q_1); 2'b11 also means no operation.
  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  // The step counter must hold the value MPLIER_W+1.
  function automatic int cnt_width(input int mplier_w);
    return $clog2(mplier_w + 2);
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle between producer, multiplier and consumer.
interface booth_mult_seq_if #(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 4
) ();
  localparam int P_W = MCAND_W + MPLIER_W;

  logic                in_valid;
  logic                in_ready;
  logic                signed_mode;
  logic [MCAND_W-1:0]  multiplicand;
  logic [MPLIER_W-1:0] multiplier;
  logic                out_valid;
  logic                out_ready;
  logic [P_W-1:0]      product;

  modport master (
    output in_valid, signed_mode, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of Mx into A,
// then an arithmetic right shift of the whole {A, Qx, q_1} chain.
module booth_step
  import booth_pkg::*;
#(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 4
) (
  input  logic [MCAND_W:0]  a,
  input  logic [MPLIER_W:0] qx,
  input  logic              q_1,
  input  logic [MCAND_W:0]  mx,
  output logic [MCAND_W:0]  a_next,
  output logic [MPLIER_W:0] qx_next,
  output logic              q_1_next
);

  logic [MCAND_W:0] sum_s;

  // Booth recode, accumulate, then shift right by one keeping A's sign.
  always_comb begin
    sum_s = a;
    case ({qx[0], q_1})
      ADD:     sum_s = a + mx;
      SUB:     sum_s = a - mx;
      NOP:     sum_s = a;
      default: sum_s = a;
    endcase
    a_next   = {sum_s[MCAND_W], sum_s[MCAND_W:1]};
    qx_next  = {sum_s[0], qx[MPLIER_W:1]};
    q_1_next = qx[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode and valid/ready on both sides.
// Takes MPLIER_W+1 data-independent steps; the product is held until the consumer takes it.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int MCAND_W  = 8,
  parameter int MPLIER_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  booth_mult_seq_if.slave bus
);

  localparam int P_W   = MCAND_W + MPLIER_W;
  localparam int A_W   = MCAND_W + 1;
  localparam int Q_W   = MPLIER_W + 1;
  localparam int CNT_W = cnt_width(MPLIER_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MPLIER_W);

  state_t           state_r;
  state_t           state_next_s;
  logic [A_W-1:0]   a_r;
  logic [A_W-1:0]   mx_r;
  logic [A_W-1:0]   a_next_s;
  logic [Q_W-1:0]   qx_r;
  logic [Q_W-1:0]   qx_next_s;
  logic             q1_r;
  logic             q1_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [P_W-1:0]   product_r;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  booth_step #(
    .MCAND_W  (MCAND_W),
    .MPLIER_W (MPLIER_W)
  ) u_step (
    .a        (a_r),
    .qx       (qx_r),
    .q_1      (q1_r),
    .mx       (mx_r),
    .a_next   (a_next_s),
    .qx_next  (qx_next_s),
    .q_1_next (q1_next_s)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = (cnt_r == LAST_CNT);
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          load_s       = 1'b1;
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand load, Booth iteration and product capture on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      mx_r      <= '0;
      qx_r      <= '0;
      q1_r      <= 1'b0;
      cnt_r     <= '0;
      product_r <= '0;
    end else if (load_s) begin
      a_r   <= '0;
      mx_r  <= {bus.signed_mode & bus.multiplicand[MCAND_W-1], bus.multiplicand};
      qx_r  <= {bus.signed_mode & bus.multiplier[MPLIER_W-1], bus.multiplier};
      q1_r  <= 1'b0;
      cnt_r <= '0;
    end else if (step_s) begin
      a_r   <= a_next_s;
      qx_r  <= qx_next_s;
      q1_r  <= q1_next_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_s) begin
        product_r <= P_W'({a_next_s, qx_next_s});
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases, backpressure,
// mid-calculation reset and a randomized stream against an arithmetic reference.
module tb_booth_mult_seq;

  localparam int MW = 8;
  localparam int QW = 4;
  localparam int PW = MW + QW;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  booth_mult_seq_if #(.MCAND_W(MW), .MPLIER_W(QW)) bus ();

  booth_mult_seq #(.MCAND_W(MW), .MPLIER_W(QW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [PW-1:0] ref_mult(input logic sm, input logic [MW-1:0] m,
                                             input logic [QW-1:0] q);
    longint      a;
    longint      b;
    logic [63:0] full;
    if (sm) begin
      a = longint'($signed(m));
      b = longint'($signed(q));
    end else begin
      a = longint'(m);
      b = longint'(q);
    end
    full = 64'(a * b);
    return full[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at a negedge.
  task automatic run_op(input string tag, input logic sm, input logic [MW-1:0] m,
                        input logic [QW-1:0] q, input logic [PW-1:0] exp,
                        input bit release_out, output int lat);
    int k;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
    bus.signed_mode  = sm;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, " in_ready after accept"}, 64'(bus.in_ready), 64'd0);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " product"}, 64'(bus.product), 64'(exp));
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, " out_valid after take"}, 64'(bus.out_valid), 64'd0);
      check({tag, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
    end
  endtask

  initial begin
    int            lat;
    logic [PW-1:0] held;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_p;
    logic          sm;
    logic [MW-1:0] m;
    logic [QW-1:0] q;
    int            sent;
    int            got;
    int            last_cycle;
    int            cyc;

    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b0;
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset product", 64'(bus.product), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("s -3x5", 1'b1, 8'hFD, 4'h5, 12'hFF1, 1'b1, lat);
    check("s -3x5 latency", 64'(lat), 64'd5);
    run_op("u 255x15", 1'b0, 8'hFF, 4'hF, 12'hEF1, 1'b1, lat);
    run_op("s -1x-1", 1'b1, 8'hFF, 4'hF, 12'h001, 1'b1, lat);
    run_op("s -128x-8", 1'b1, 8'h80, 4'h8, 12'h400, 1'b1, lat);
    run_op("u 128x8", 1'b0, 8'h80, 4'h8, 12'h400, 1'b1, lat);
    run_op("s 127x-8", 1'b1, 8'h7F, 4'h8, 12'hC08, 1'b1, lat);
    check("s 127x-8 latency", 64'(lat), 64'd5);

    // Backpressure: result held while new operands are offered and ignored.
    run_op("bp", 1'b1, 8'hF6, 4'h7, 12'hFBA, 1'b0, lat);
    held = bus.product;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid     = (i % 2 == 0);
      bus.signed_mode  = 1'b0;
      bus.multiplicand = 8'h11;
      bus.multiplier   = 4'h3;
      @(posedge clk);
      @(negedge clk);
      check("bp product stable", 64'(bus.product), 64'(held));
      check("bp in_ready low", 64'(bus.in_ready), 64'd0);
      check("bp out_valid high", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp released out_valid", 64'(bus.out_valid), 64'd0);
    check("bp released in_ready", 64'(bus.in_ready), 64'd1);
    run_op("after bp 5x6", 1'b1, 8'h05, 4'h6, 12'h01E, 1'b1, lat);

    // Reset after the second Booth step.
    bus.signed_mode  = 1'b0;
    bus.multiplicand = 8'hC3;
    bus.multiplier   = 4'hB;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midcalc rst out_valid", 64'(bus.out_valid), 64'd0);
    check("midcalc rst product", 64'(bus.product), 64'd0);
    check("midcalc rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst in_ready", 64'(bus.in_ready), 64'd1);
    check("post rst out_valid", 64'(bus.out_valid), 64'd0);
    run_op("s 7x3", 1'b1, 8'h07, 4'h3, 12'h015, 1'b1, lat);

    // Streaming with in_valid and out_ready held high.
    sent          = 0;
    got           = 0;
    last_cycle    = -1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (cyc = 0; cyc < 200 * 7 + 60 && got < 200; cyc++) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected result", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_p = exp_q.pop_front();
          check("stream product", 64'(bus.product), 64'(exp_p));
        end
        if (last_cycle >= 0) begin
          check("stream spacing", 64'(cyc - last_cycle), 64'd7);
        end
        last_cycle = cyc;
        got++;
      end
      if (bus.in_ready) begin
        if (sent < 200) begin
          sm = 1'($urandom_range(0, 1));
          m  = MW'($urandom);
          q  = QW'($urandom);
          bus.signed_mode  = sm;
          bus.multiplicand = m;
          bus.multiplier   = q;
          exp_q.push_back(ref_mult(sm, m, q));
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream result count", 64'(got), 64'd200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
